// File: rtl/cam_pkg.sv
`default_nettype none
// cam_pkg: entry type and match-vector helpers shared by the ternary CAM slice.
// Revision 1.0
package cam_pkg;

  // Widest key and deepest array the shared helpers support.
  localparam int CAM_MAX_WIDTH = 64;
  localparam int CAM_MAX_DEPTH = 256;

  typedef struct packed {
    logic [CAM_MAX_WIDTH-1:0] data;
    logic [CAM_MAX_WIDTH-1:0] mask;
    logic                     valid;
  } cam_entry_t;

  // Lowest set index wins; returns 0 for an all-zero vector.
  function automatic logic [7:0] cam_prio_enc(input logic [CAM_MAX_DEPTH-1:0] vec);
    logic [7:0] idx;
    idx = '0;
    for (int i = CAM_MAX_DEPTH - 1; i >= 0; i--) begin
      if (vec[i]) idx = 8'(i);
    end
    return idx;
  endfunction

  // Clearing the lowest set bit leaves something only if two or more were set.
  function automatic logic cam_multi_hit(input logic [CAM_MAX_DEPTH-1:0] vec);
    return (vec & (vec - CAM_MAX_DEPTH'(1))) != '0;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cam_if.sv
`default_nettype none
// cam_if: command and result bus of the ternary CAM array.
// Revision 1.0
interface cam_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int ADDR_W = $clog2(DEPTH);

  logic              write_enable_i;
  logic [ADDR_W-1:0] write_addr_i;
  logic [WIDTH-1:0]  write_data_i;
  logic [WIDTH-1:0]  write_mask_i;
  logic              invalidate_enable_i;
  logic [ADDR_W-1:0] invalidate_addr_i;
  logic              search_enable_i;
  logic [WIDTH-1:0]  search_data_i;
  logic              read_enable_i;
  logic [ADDR_W-1:0] read_addr_i;
  logic [WIDTH-1:0]  read_data_o;
  logic [WIDTH-1:0]  read_mask_o;
  logic              read_valid_o;
  logic              read_done_o;
  logic              search_done_o;
  logic [DEPTH-1:0]  match_vec_o;
  logic              hit_o;
  logic [ADDR_W-1:0] hit_index_o;
  logic              multi_hit_o;
  logic [ADDR_W:0]   occupancy_o;
  logic              full_o;

  modport master (
    output write_enable_i, write_addr_i, write_data_i, write_mask_i,
    output invalidate_enable_i, invalidate_addr_i,
    output search_enable_i, search_data_i, read_enable_i, read_addr_i,
    input  read_data_o, read_mask_o, read_valid_o, read_done_o,
    input  search_done_o, match_vec_o, hit_o, hit_index_o, multi_hit_o,
    input  occupancy_o, full_o
  );

  modport slave (
    input  write_enable_i, write_addr_i, write_data_i, write_mask_i,
    input  invalidate_enable_i, invalidate_addr_i,
    input  search_enable_i, search_data_i, read_enable_i, read_addr_i,
    output read_data_o, read_mask_o, read_valid_o, read_done_o,
    output search_done_o, match_vec_o, hit_o, hit_index_o, multi_hit_o,
    output occupancy_o, full_o
  );
endinterface
`default_nettype wire

// File: rtl/cam_entry.sv
`default_nettype none
// cam_entry: storage for one ternary CAM row plus its combinational match.
// Revision 1.0
module cam_entry
  import cam_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             write_en_i,
  input  logic [WIDTH-1:0] write_data_i,
  input  logic [WIDTH-1:0] write_mask_i,
  input  logic             invalidate_i,
  input  logic [WIDTH-1:0] search_data_i,
  output logic             match_o,
  output cam_entry_t       entry_o
);

  cam_entry_t entry_d, entry_q;

  // Write is applied after invalidate so a same-cycle write leaves the row valid.
  always_comb begin
    entry_d = entry_q;
    if (invalidate_i) entry_d.valid = 1'b0;
    if (write_en_i) begin
      entry_d.data  = CAM_MAX_WIDTH'(write_data_i);
      entry_d.mask  = CAM_MAX_WIDTH'(write_mask_i);
      entry_d.valid = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) entry_q <= '0;
    else        entry_q <= entry_d;
  end

  assign match_o = entry_q.valid &&
                   (((search_data_i ^ WIDTH'(entry_q.data)) & WIDTH'(entry_q.mask)) == '0);
  assign entry_o = entry_q;

endmodule
`default_nettype wire

// File: rtl/cam_array.sv
`default_nettype none
// cam_array: DEPTH x WIDTH ternary CAM with registered search, read and occupancy.
// Revision 1.0
module cam_array
  import cam_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
) (
  input logic  clk,
  input logic  reset,
  cam_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);

  logic [DEPTH-1:0] match_w;
  logic [DEPTH-1:0] valid_w;
  logic [DEPTH-1:0] we_w;
  logic [DEPTH-1:0] inv_w;
  cam_entry_t       entries_w [DEPTH];

  for (genvar i = 0; i < DEPTH; i++) begin : g_entry
    assign we_w[i]    = bus.write_enable_i && (bus.write_addr_i == ADDR_W'(i));
    assign inv_w[i]   = bus.invalidate_enable_i && (bus.invalidate_addr_i == ADDR_W'(i));
    assign valid_w[i] = entries_w[i].valid;

    cam_entry #(.WIDTH(WIDTH)) u_entry (
      .clk           (clk),
      .reset         (reset),
      .write_en_i    (we_w[i]),
      .write_data_i  (bus.write_data_i),
      .write_mask_i  (bus.write_mask_i),
      .invalidate_i  (inv_w[i]),
      .search_data_i (bus.search_data_i),
      .match_o       (match_w[i]),
      .entry_o       (entries_w[i])
    );
  end

  logic              inc_w, dec_w;
  logic [ADDR_W:0]   occupancy_d, occupancy_q;
  logic [DEPTH-1:0]  match_vec_d, match_vec_q;
  logic              hit_d, hit_q, multi_hit_d, multi_hit_q, search_done_d, search_done_q;
  logic [ADDR_W-1:0] hit_index_d, hit_index_q;
  logic [WIDTH-1:0]  read_data_d, read_data_q, read_mask_d, read_mask_q;
  logic              read_valid_d, read_valid_q, read_done_d, read_done_q;

  // Occupancy tracks valid-bit transitions; a same-address write cancels the invalidate.
  assign inc_w = bus.write_enable_i && !valid_w[bus.write_addr_i];
  assign dec_w = bus.invalidate_enable_i && valid_w[bus.invalidate_addr_i] &&
                 !(bus.write_enable_i && (bus.write_addr_i == bus.invalidate_addr_i));

  always_comb begin
    occupancy_d   = occupancy_q + (ADDR_W+1)'(inc_w) - (ADDR_W+1)'(dec_w);
    match_vec_d   = match_vec_q;
    hit_d         = hit_q;
    hit_index_d   = hit_index_q;
    multi_hit_d   = multi_hit_q;
    search_done_d = bus.search_enable_i;
    if (bus.search_enable_i) begin
      match_vec_d = match_w;
      hit_d       = |match_w;
      hit_index_d = ADDR_W'(cam_prio_enc(CAM_MAX_DEPTH'(match_w)));
      multi_hit_d = cam_multi_hit(CAM_MAX_DEPTH'(match_w));
    end
    read_data_d  = read_data_q;
    read_mask_d  = read_mask_q;
    read_valid_d = read_valid_q;
    read_done_d  = bus.read_enable_i;
    if (bus.read_enable_i) begin
      read_data_d  = WIDTH'(entries_w[bus.read_addr_i].data);
      read_mask_d  = WIDTH'(entries_w[bus.read_addr_i].mask);
      read_valid_d = entries_w[bus.read_addr_i].valid;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      occupancy_q   <= '0;
      match_vec_q   <= '0;
      hit_q         <= 1'b0;
      hit_index_q   <= '0;
      multi_hit_q   <= 1'b0;
      search_done_q <= 1'b0;
      read_data_q   <= '0;
      read_mask_q   <= '0;
      read_valid_q  <= 1'b0;
      read_done_q   <= 1'b0;
    end else begin
      occupancy_q   <= occupancy_d;
      match_vec_q   <= match_vec_d;
      hit_q         <= hit_d;
      hit_index_q   <= hit_index_d;
      multi_hit_q   <= multi_hit_d;
      search_done_q <= search_done_d;
      read_data_q   <= read_data_d;
      read_mask_q   <= read_mask_d;
      read_valid_q  <= read_valid_d;
      read_done_q   <= read_done_d;
    end
  end

  assign bus.occupancy_o   = occupancy_q;
  assign bus.full_o        = (occupancy_q == (ADDR_W+1)'(DEPTH));
  assign bus.match_vec_o   = match_vec_q;
  assign bus.hit_o         = hit_q;
  assign bus.hit_index_o   = hit_index_q;
  assign bus.multi_hit_o   = multi_hit_q;
  assign bus.search_done_o = search_done_q;
  assign bus.read_data_o   = read_data_q;
  assign bus.read_mask_o   = read_mask_q;
  assign bus.read_valid_o  = read_valid_q;
  assign bus.read_done_o   = read_done_q;

endmodule
`default_nettype wire

// File: tb/tb_cam_array.sv
`default_nettype none
// tb_cam_array: directed and random stimulus against an array-based CAM model.
// Revision 1.0
module tb_cam_array;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cam_if #(.WIDTH(WIDTH), .DEPTH(DEPTH)) bus ();
  cam_array #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (.clk(clk), .reset(rst_n), .bus(bus));

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] m_data  [DEPTH];
  logic [WIDTH-1:0] m_mask  [DEPTH];
  logic             m_valid [DEPTH];

  logic [DEPTH-1:0] e_match;
  logic             e_hit, e_multi, e_sdone, e_rdone, e_rvalid;
  logic [AW-1:0]    e_idx;
  logic [WIDTH-1:0] e_rdata, e_rmask;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic idle();
    bus.write_enable_i      = 1'b0;
    bus.invalidate_enable_i = 1'b0;
    bus.search_enable_i     = 1'b0;
    bus.read_enable_i       = 1'b0;
    bus.write_addr_i        = '0;
    bus.write_data_i        = '0;
    bus.write_mask_i        = '0;
    bus.invalidate_addr_i   = '0;
    bus.search_data_i       = '0;
    bus.read_addr_i         = '0;
  endtask

  task automatic model_reset();
    for (int i = 0; i < DEPTH; i++) begin
      m_data[i] = '0; m_mask[i] = '0; m_valid[i] = 1'b0;
    end
    e_match = '0; e_hit = 0; e_multi = 0; e_sdone = 0; e_rdone = 0;
    e_rvalid = 0; e_idx = '0; e_rdata = '0; e_rmask = '0;
  endtask

  task automatic check_all();
    int occ;
    occ = 0;
    for (int i = 0; i < DEPTH; i++) occ += int'(m_valid[i]);
    chk("search_done", bus.search_done_o, e_sdone);
    chk("match_vec",   bus.match_vec_o,   e_match);
    chk("hit",         bus.hit_o,         e_hit);
    chk("hit_index",   bus.hit_index_o,   e_idx);
    chk("multi_hit",   bus.multi_hit_o,   e_multi);
    chk("read_done",   bus.read_done_o,   e_rdone);
    chk("read_data",   bus.read_data_o,   e_rdata);
    chk("read_mask",   bus.read_mask_o,   e_rmask);
    chk("read_valid",  bus.read_valid_o,  e_rvalid);
    chk("occupancy",   bus.occupancy_o,   64'(occ));
    chk("full",        bus.full_o,        64'(occ == DEPTH));
  endtask

  // Called just after a rising edge with inputs already driven; one clock, then check.
  task automatic cycle();
    int cnt;
    if (bus.search_enable_i) begin
      e_match = '0; e_hit = 1'b0; e_idx = '0; cnt = 0;
      for (int i = 0; i < DEPTH; i++) begin
        if (m_valid[i] && (((bus.search_data_i ^ m_data[i]) & m_mask[i]) == '0)) begin
          e_match[i] = 1'b1;
          if (cnt == 0) e_idx = AW'(i);
          cnt++;
        end
      end
      e_hit   = (cnt > 0);
      e_multi = (cnt >= 2);
    end
    e_sdone = bus.search_enable_i;
    if (bus.read_enable_i) begin
      e_rdata  = m_data[bus.read_addr_i];
      e_rmask  = m_mask[bus.read_addr_i];
      e_rvalid = m_valid[bus.read_addr_i];
    end
    e_rdone = bus.read_enable_i;
    if (bus.invalidate_enable_i) m_valid[bus.invalidate_addr_i] = 1'b0;
    if (bus.write_enable_i) begin
      m_data[bus.write_addr_i]  = bus.write_data_i;
      m_mask[bus.write_addr_i]  = bus.write_mask_i;
      m_valid[bus.write_addr_i] = 1'b1;
    end
    @(posedge clk);
    #1;
    check_all();
    idle();
  endtask

  task automatic set_write(input int a, input logic [WIDTH-1:0] d, input logic [WIDTH-1:0] m);
    bus.write_enable_i = 1'b1;
    bus.write_addr_i   = AW'(a);
    bus.write_data_i   = d;
    bus.write_mask_i   = m;
  endtask

  task automatic set_inv(input int a);
    bus.invalidate_enable_i = 1'b1;
    bus.invalidate_addr_i   = AW'(a);
  endtask

  task automatic set_search(input logic [WIDTH-1:0] k);
    bus.search_enable_i = 1'b1;
    bus.search_data_i   = k;
  endtask

  task automatic set_read(input int a);
    bus.read_enable_i = 1'b1;
    bus.read_addr_i   = AW'(a);
  endtask

  initial begin
    idle();
    model_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Empty array: search completes with no hit.
    set_search(32'hDEADBEEF); cycle();
    chk("tp_empty_done", bus.search_done_o, 1);

    set_write(3, 32'h12345678, 32'hFFFFFFFF); cycle();
    set_search(32'h12345678); cycle();
    chk("tp_idx3", bus.hit_index_o, 3);

    set_write(5, 32'h12340000, 32'hFFFF0000); cycle();
    set_search(32'h12345678); cycle();
    chk("tp_match35", bus.match_vec_o, 16'h0028);
    chk("tp_multi", bus.multi_hit_o, 1);
    set_inv(3); cycle();
    set_search(32'h12345678); set_read(3); cycle();
    chk("tp_idx5", bus.hit_index_o, 5);

    // Same-address write+invalidate, with a same-cycle search seeing old contents.
    set_write(7, 32'hCAFEF00D, 32'hFFFFFFFF); set_inv(7); set_search(32'hCAFEF00D); cycle();
    chk("tp_wi_nohit", bus.hit_o, 0);
    set_search(32'hCAFEF00D); set_read(7); cycle();
    chk("tp_idx7", bus.hit_index_o, 7);

    for (int i = 0; i < DEPTH; i++) begin
      set_write(i, 32'hA0000000 + 32'(i), 32'hFFFFFFFF); cycle();
    end
    chk("tp_full", bus.full_o, 1);
    set_write(0, 32'h0BADF00D, 32'h0000FFFF); set_read(0); cycle();
    set_inv(0); set_read(0); cycle();
    set_inv(0); cycle();
    chk("tp_occ15", bus.occupancy_o, 15);
    set_write(2, 32'h11111111, 32'hFFFFFFFF); set_inv(4); cycle();

    // Reset lands while a hitting search is waiting for its capture edge.
    set_search(32'hA0000005);
    #2;
    rst_n = 1'b0;
    model_reset();
    @(posedge clk);
    #1;
    check_all();
    idle();
    @(negedge clk) rst_n = 1'b1;
    @(posedge clk);
    #1;
    set_read(5); cycle();
    chk("tp_rst_rvalid", bus.read_valid_o, 0);

    for (int n = 0; n < 400; n++) begin
      logic [WIDTH-1:0] m;
      case ($urandom_range(0, 7))
        0, 1, 2: m = 32'hFFFFFFFF;
        3, 4:    m = 32'hFFFF0000;
        5, 6:    m = 32'hFFFFFFF8;
        default: m = 32'h00000000;
      endcase
      if ($urandom_range(0, 2) == 0)
        set_write($urandom_range(0, DEPTH-1), 32'h5A5A0000 | 32'($urandom_range(0, 7)), m);
      if ($urandom_range(0, 3) == 0) set_inv($urandom_range(0, DEPTH-1));
      if ($urandom_range(0, 1) == 0) set_search(32'h5A5A0000 | 32'($urandom_range(0, 7)));
      if ($urandom_range(0, 1) == 0) set_read($urandom_range(0, DEPTH-1));
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
`default_nettype wire
